// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// States, FIFO entry layout and fetch step size.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instructions.
// Flush wins over push and pop; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0
                                 : p + PW'(1);
  endfunction

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads imem over req/ack,
// buffers words for decode and restarts on redirect.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [3:0]  dec_cond,
  output logic [1:0]  dec_op,
  output logic [5:0]  dec_funct,
  output logic [3:0]  dec_rd
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_n;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          push;
  logic          pop;
  logic          issue;
  logic          done;
  logic          busy_ack;
  logic          full;
  logic          empty;
  fetch_entry_t  entry;
  fetch_entry_t  head;

  assign entry = '{instr: imem_rdata,
                   pc: imem_addr};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (entry),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n  = state;
    busy_ack = (state == BUSY) && imem_ack;
    push     = busy_ack && !redirect && !full;
    pop      = !empty && dec_ready && !redirect;
    count_n  = redirect ? '0
             : count + CW'(push) - CW'(pop);
    pc_n     = fetch_pc;
    if (redirect)
      pc_n = {redirect_addr[31:2], 2'b00};
    else if (busy_ack)
      pc_n = fetch_pc + 32'(INSTR_BYTES);
    // no request remains outstanding after this edge
    done  = (state == IDLE) || imem_ack;
    issue = done && (count_n < CW'(DEPTH));
    unique case (1'b1)
      issue:          state_n = BUSY;
      done && !issue: state_n = IDLE;
      !done:          state_n =
        (redirect || state == DRAIN) ? DRAIN
                                     : BUSY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      state    <= state_n;
      imem_req <= state_n != IDLE;
      fetch_pc <= pc_n;
      if (issue) imem_addr <= pc_n;
    end
  end

  assign dec_valid = !empty;
  assign dec_instr = head.instr;
  assign dec_pc    = head.pc;
  assign dec_cond  = head.instr[31:28];
  assign dec_op    = head.instr[27:26];
  assign dec_funct = head.instr[25:20];
  assign dec_rd    = head.instr[15:12];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Returned instructions go into a small FIFO and are presented to decode with valid/ready, with the `op`/`funct`/`rd`/`cond` fields pre-split. Branch and PC-write redirects from execute flush the FIFO and restart fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `DEPTH`, 2: instruction FIFO entries; legal range 2..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  read request, registered.
- `imem_addr`  out  32  word address, registered, bits [1:0] always 0.
- `imem_ack`  in  1  request accepted; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  one-cycle pulse from execute (`pcs` taken).
- `redirect_addr`  in  32  new PC; bits [1:0] are ignored (forced to 0).
- `dec_valid`  out  1  FIFO head is valid.
- `dec_ready`  in  1  decoder consumes the head this cycle.
- `dec_instr`  out  32  head instruction word.
- `dec_pc`  out  32  address of the head instruction.
- `dec_cond`  out  4  `dec_instr[31:28]`.
- `dec_op`  out  2  `dec_instr[27:26]`.
- `dec_funct`  out  6  `dec_instr[25:20]`.
- `dec_rd`  out  4  `dec_instr[15:12]`.

## Operation
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`, FIFO empty, `dec_valid`=0. All `dec_*` data outputs are 0 while the FIFO is empty.
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: request outstanding, response will be kept.
  - DRAIN: request outstanding, response will be discarded.
- Issue rule: a request is issued only when the FSM is in IDLE, or when it is in BUSY and acked this cycle. It also requires `count + (request still outstanding after this edge) < DEPTH`, so a push never reaches a full FIFO.
- Once `imem_req` is high, `imem_req` and `imem_addr` hold until `imem_ack`. A request is never withdrawn.
- Ack in BUSY:
  - Push {`imem_rdata`, `imem_addr`}.
  - `fetch_pc` += 4, wrapping modulo 2^32 (0xFFFF_FFFC → 0).
  - Next state is BUSY if a new request is issued, otherwise IDLE.
- Ack in DRAIN: data is dropped, nothing is pushed, and the issue rule is re-evaluated from `fetch_pc`.
- Pop happens when `dec_valid && dec_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect (highest priority):
  - Flush the FIFO (`count`=0); any same-cycle pop or push is discarded.
  - `fetch_pc` = `{redirect_addr[31:2], 2'b00}`.
  - From IDLE: the next request uses the new PC.
  - From BUSY without ack: go to DRAIN.
  - From BUSY with ack, or from DRAIN with ack: the data is dropped, and a request to the new PC may issue at the same edge.
  - From DRAIN without ack: stay in DRAIN; the PC is updated.
- `dec_valid` deasserts the cycle after a redirect edge. A stale instruction is never presented after a redirect.
- Asserting `rst_n` low mid-transaction returns everything to reset values immediately. Any ack arriving during reset is ignored.

## Timing
- First `imem_req`=1 appears at the first rising edge after `rst_n` deasserts.
- Latency: from the ack edge to `dec_valid`=1 is one edge; data is registered in the FIFO.
- Throughput: with a same-cycle ack and `dec_ready`=1 held, one instruction per cycle, and `imem_addr` advances by 4 each cycle.
- Redirect to first new-PC request:
  - 1 edge from IDLE, or when the redirect coincides with an ack.
  - Otherwise, 1 edge after the draining ack.
- `dec_*` outputs change only on clock edges; they are not combinational from `dec_ready` or `imem_ack`.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum {IDLE, BUSY, DRAIN}.
  - `fetch_entry_t` struct {instr[31:0], pc[31:0]}.
  - Localparam `INSTR_BYTES`=4.
- One sub-module, `fetch_fifo`: parameterised synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, full and empty. Flush has priority over push and pop. Instantiated once.
- The field split (`dec_op`, `dec_funct`, `dec_rd`, `dec_cond`) is continuous assignment in the top level.

## Test plan
- Reset release with memory acking every cycle and `dec_ready`=1 → `imem_addr` 0x0, 0x4, 0x8 on consecutive cycles. `dec_pc` follows one cycle later, and `dec_op`/`dec_funct`/`dec_rd` match `imem_rdata` slices.
- `dec_ready`=0 held with DEPTH=2 → exactly 2 pushes and no third request. Raising `dec_ready` resumes fetch at 0x8.
- Ack delayed 3 cycles → `imem_req`/`imem_addr` stay stable the whole time, and one entry is pushed on the ack.
- Redirect to 0x103 while a request to 0x8 is outstanding and unacked → DRAIN. The 0x8 data is never presented; the next request is to 0x100, and `dec_pc`=0x100.
- Redirect coincident with ack and with a pop while the FIFO holds 2 entries → FIFO empty next cycle, `dec_valid`=0, and the request to the new PC issues the same edge.
- `RESET_PC`=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Then pull `rst_n` low mid-request → `imem_req`=0 immediately.
